// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: shared constants and state encoding for the camera register configuration sequencer.
// Table entries are {device address, register, value}, each 8 bits wide.
package cam_cfg_pkg;
    localparam int DEV_W     = 8;
    localparam int REG_W     = 8;
    localparam int VAL_W     = 8;
    localparam int ENTRY_W   = DEV_W + REG_W + VAL_W;
    localparam int SETUP_CYC = 2;
    localparam int CNT_W     = 16;
    typedef enum logic [2:0] {
        S_PWRUP,
        S_SETUP,
        S_XFER,
        S_CHECK,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_e;
endpackage

// File: rtl/cfg_delay_cnt.sv
// cfg_delay_cnt: loadable down-counter shared by the power-up wait and the transfer timeout.
// Ports: clk_i / rst_ni  clock and asynchronous active-low reset
//        load_i / val_i  load a new count (takes priority over counting)
//        busy_o          count is nonzero
//        done_o          last cycle of the loaded count (count == 1)
module cfg_delay_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         busy_o,
    output logic         done_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign busy_o = cnt_q != '0;
    assign done_o = cnt_q == W'(1);

    always_comb cnt_d = load_i ? val_i : (busy_o ? cnt_q - W'(1) : cnt_q);

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/cam_reg_cfg_seq.sv
// cam_reg_cfg_seq: walks a LUT of {dev, reg, val} words and hands each to an I2C write engine.
// Ports: clock_i2c / rstn     I2C bit-rate clock, asynchronous active-low reset
//        cfg_go               one-cycle pulse restarting configuration from DONE or ERR
//        lut_index / lut_data address to and entry from the external combinational ROM
//        i2c_data / start     latched word and run/clear control for the write engine
//        tr_end / ack         engine end-of-transfer level and combined NACK flag
//        cfg_done / cfg_err   completion and abort status
//        nack_cnt             saturating count of NACKs and timeouts
// Option: define I2C_CFG_RETRY_EN to retry a failing entry up to MAX_RETRY times before ERR.
// PWRUP_CYC and XFER_TMO must be at least 1 and fit in CNT_W bits.
module cam_reg_cfg_seq
    import cam_cfg_pkg::*;
#(
    parameter int LUT_SIZE  = 16,
    parameter int PWRUP_CYC = 2000,
    parameter int MAX_RETRY = 3,
    parameter int XFER_TMO  = 200
) (
    input  logic               clock_i2c,
    input  logic               rstn,
    input  logic               cfg_go,
    output logic [7:0]         lut_index,
    input  logic [ENTRY_W-1:0] lut_data,
    output logic [ENTRY_W-1:0] i2c_data,
    output logic               start,
    input  logic               tr_end,
    input  logic               ack,
    output logic               cfg_done,
    output logic               cfg_err,
    output logic [7:0]         nack_cnt
);
    // The first PWRUP cycle is spent loading the counter, so load one less.
    localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWRUP_CYC > 1 ? PWRUP_CYC - 1 : 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(XFER_TMO);
    localparam logic [7:0]       LAST_IDX = 8'(LUT_SIZE - 1);
    localparam logic [1:0]       SET_LAST = 2'(SETUP_CYC - 1);

    state_e             state_q;
    state_e             state_d;
    logic [7:0]         idx_q;
    logic [7:0]         idx_d;
    logic [ENTRY_W-1:0] data_q;
    logic [ENTRY_W-1:0] data_d;
    logic [7:0]         nack_q;
    logic [7:0]         nack_d;
    logic [1:0]         set_q;
    logic [1:0]         set_d;
    logic               tmo_q;
    logic               tmo_d;
    logic               dly_load;
    logic [CNT_W-1:0]   dly_val;
    logic               dly_busy;
    logic               dly_done;
`ifdef I2C_CFG_RETRY_EN
    logic [7:0]         retry_q;
    logic [7:0]         retry_d;
`endif

    cfg_delay_cnt #(.W(CNT_W)) u_dly (
        .clk_i  (clock_i2c),
        .rst_ni (rstn),
        .load_i (dly_load),
        .val_i  (dly_val),
        .busy_o (dly_busy),
        .done_o (dly_done)
    );

    assign start     = (state_q == S_XFER) || (state_q == S_CHECK);
    assign cfg_done  = state_q == S_DONE;
    assign cfg_err   = state_q == S_ERR;
    assign lut_index = idx_q;
    assign i2c_data  = data_q;
    assign nack_cnt  = nack_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        nack_d   = nack_q;
        set_d    = set_q;
        tmo_d    = tmo_q;
        dly_load = 1'b0;
        dly_val  = PWR_LOAD;
`ifdef I2C_CFG_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            S_PWRUP: begin
                dly_load = !dly_busy;
                if (dly_done) begin
                    state_d = S_SETUP;
                    idx_d   = '0;
                end
            end
            S_SETUP: begin
                set_d = set_q + 2'd1;
                if (set_q == SET_LAST) begin
                    data_d   = lut_data;
                    dly_load = 1'b1;
                    dly_val  = TMO_LOAD;
                    tmo_d    = 1'b0;
                    set_d    = '0;
                    state_d  = S_XFER;
                end
            end
            S_XFER: begin
                if (tr_end) state_d = S_CHECK;
                else if (dly_done) begin
                    tmo_d   = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!ack && !tmo_q) state_d = S_NEXT;
                else begin
                    nack_d  = (nack_q == 8'hFF) ? nack_q : nack_q + 8'd1;
`ifdef I2C_CFG_RETRY_EN
                    retry_d = (int'(retry_q) < MAX_RETRY) ? retry_q + 8'd1 : retry_q;
                    state_d = (int'(retry_q) < MAX_RETRY) ? S_SETUP : S_ERR;
`else
                    state_d = S_ERR;
`endif
                end
            end
            S_NEXT: begin
`ifdef I2C_CFG_RETRY_EN
                retry_d = '0;
`endif
                state_d = (idx_q == LAST_IDX) ? S_DONE : S_SETUP;
                idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 8'd1;
            end
            S_DONE, S_ERR: begin
                if (cfg_go) begin
                    idx_d   = '0;
                    state_d = S_SETUP;
`ifdef I2C_CFG_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            default: state_d = S_PWRUP;
        endcase
    end

    always_ff @(posedge clock_i2c or negedge rstn)
        if (!rstn) begin
            state_q <= S_PWRUP;
            idx_q   <= '0;
            data_q  <= '0;
            nack_q  <= '0;
            set_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            nack_q  <= nack_d;
            set_q   <= set_d;
            tmo_q   <= tmo_d;
        end

`ifdef I2C_CFG_RETRY_EN
    always_ff @(posedge clock_i2c or negedge rstn)
        if (!rstn) retry_q <= '0;
        else retry_q <= retry_d;
`endif
endmodule

// File: tb/tb_cam_reg_cfg_seq.sv
// tb_cam_reg_cfg_seq: self-checking bench for cam_reg_cfg_seq with a behavioural I2C engine and ROM.
module tb_cam_reg_cfg_seq;
    localparam int LUT_SIZE  = 4;
    localparam int PWRUP_CYC = 20;
    localparam int MAX_RETRY = 3;
    localparam int XFER_TMO  = 200;
    localparam int SETUP_CYC = 2;
    localparam int ENG_LAT   = 3;

    logic        clock_i2c = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_go = 1'b0;
    logic [7:0]  lut_index;
    logic [23:0] lut_data;
    logic [23:0] i2c_data;
    logic        start;
    logic        tr_end;
    logic        ack;
    logic        cfg_done;
    logic        cfg_err;
    logic [7:0]  nack_cnt;
    logic [23:0] rom [LUT_SIZE];

    always #5 clock_i2c = ~clock_i2c;

    cam_reg_cfg_seq #(
        .LUT_SIZE  (LUT_SIZE),
        .PWRUP_CYC (PWRUP_CYC),
        .MAX_RETRY (MAX_RETRY),
        .XFER_TMO  (XFER_TMO)
    ) dut (
        .clock_i2c (clock_i2c),
        .rstn      (rstn),
        .cfg_go    (cfg_go),
        .lut_index (lut_index),
        .lut_data  (lut_data),
        .i2c_data  (i2c_data),
        .start     (start),
        .tr_end    (tr_end),
        .ack       (ack),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .nack_cnt  (nack_cnt)
    );

    assign lut_data = (int'(lut_index) < LUT_SIZE) ? rom[lut_index[1:0]] : 24'h0;

    // Engine model: ends each transfer ENG_LAT cycles after it sees start, optionally
    // NACKing or never ending for the first N attempts at one chosen entry.
    int   nack_idx = -1;
    int   nack_n = 0;
    int   hang_idx = -1;
    int   hang_n = 0;
    int   att [LUT_SIZE];
    int   eng_cnt;
    logic eng_hang;
    logic eng_nack;

    always @(posedge clock_i2c) begin
        if (!rstn || !start) begin
            eng_cnt <= 0;
            tr_end  <= 1'b0;
            ack     <= 1'b0;
            if (!rstn) for (int i = 0; i < LUT_SIZE; i++) att[i] <= 0;
        end else begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 0) begin
                eng_hang <= (int'(lut_index) == hang_idx) && (att[lut_index[1:0]] < hang_n);
                eng_nack <= (int'(lut_index) == nack_idx) && (att[lut_index[1:0]] < nack_n);
                att[lut_index[1:0]] <= att[lut_index[1:0]] + 1;
            end
            if (eng_cnt == ENG_LAT && !eng_hang) begin
                tr_end <= 1'b1;
                ack    <= eng_nack;
            end
        end
    end

    typedef struct {
        string name;
        int    ni;
        int    nn;
        int    hi;
        int    hn;
        int    done;
        int    err;
        int    idx;
        int    nacks;
        int    starts;
    } vec_t;

    vec_t        vecs [5];
    int          checks = 0;
    int          failures = 0;
    int          start_cnt = 0;
    int          run_cur = 0;
    int          first_run = 0;
    logic        start_prev = 1'b0;
    logic [23:0] exp_q [$];

    function automatic vec_t mk(input string nm, input int ni, input int nn, input int hi, input int hn,
                                input int d, input int e, input int ix, input int nk, input int st);
        vec_t v;
        v.name = nm; v.ni = ni; v.nn = nn; v.hi = hi; v.hn = hn;
        v.done = d; v.err = e; v.idx = ix; v.nacks = nk; v.starts = st;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every wait goes through here: samples on the falling edge and scores each new transfer.
    task automatic tick();
        @(negedge clock_i2c);
        if (start && !start_prev) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_start: got i2c_data %0h with no expected word", i2c_data);
            end else check("i2c_data", 32'(i2c_data), 32'(exp_q.pop_front()));
        end
        if (start) run_cur++;
        else begin
            if (start_prev && first_run == 0) first_run = run_cur;
            run_cur = 0;
        end
        start_prev = start;
    endtask

    // Reference model of which words reach the engine for a given fault pattern.
    task automatic push_run(input int ni, input int nn, input int hi, input int hn);
        for (int e = 0; e < LUT_SIZE; e++) begin
            int f;
            int tries;
            bit stop;
            f = (e == ni) ? nn : (e == hi) ? hn : 0;
`ifdef I2C_CFG_RETRY_EN
            stop  = f > MAX_RETRY;
            tries = stop ? MAX_RETRY + 1 : f + 1;
`else
            stop  = f > 0;
            tries = 1;
`endif
            repeat (tries) exp_q.push_back(rom[e]);
            if (stop) break;
        end
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        cfg_go = 1'b0;
        repeat (3) tick();
        check("rst_start", 32'(start), 0);
        check("rst_idx", 32'(lut_index), 0);
        check("rst_data", 32'(i2c_data), 0);
        check("rst_done", 32'(cfg_done), 0);
        check("rst_err", 32'(cfg_err), 0);
        check("rst_nack", 32'(nack_cnt), 0);
        exp_q.delete();
        first_run = 0;
    endtask

    task automatic wait_first_start(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!start && n < 5000);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(cfg_done || cfg_err) && n < 20000) begin
            tick();
            n++;
        end
        check("finish_in_budget", 32'(cfg_done || cfg_err), 1);
    endtask

    initial begin
        int n;
        int s0;
        for (int i = 0; i < LUT_SIZE; i++) rom[i] = {8'h78, 8'(8'h10 + i), 8'(8'hA0 + 3 * i)};
`ifdef I2C_CFG_RETRY_EN
        vecs[0] = mk("all_ack",  -1, 0, -1, 0, 1, 0, 3, 0, 4);
        vecs[1] = mk("e2_nack2",  2, 2, -1, 0, 1, 0, 3, 2, 6);
        vecs[2] = mk("e1_nack1",  1, 1, -1, 0, 1, 0, 3, 1, 5);
        vecs[3] = mk("e0_hang",  -1, 0,  0, 1, 1, 0, 3, 1, 5);
        vecs[4] = mk("e3_nack4",  3, 4, -1, 0, 0, 1, 3, 4, 7);
`else
        vecs[0] = mk("all_ack",  -1, 0, -1, 0, 1, 0, 3, 0, 4);
        vecs[1] = mk("e2_nack2",  2, 2, -1, 0, 0, 1, 2, 1, 3);
        vecs[2] = mk("e1_nack1",  1, 1, -1, 0, 0, 1, 1, 1, 2);
        vecs[3] = mk("e0_hang",  -1, 0,  0, 1, 0, 1, 0, 1, 1);
        vecs[4] = mk("e3_nack4",  3, 4, -1, 0, 0, 1, 3, 1, 4);
`endif
        foreach (vecs[k]) begin
            nack_idx = vecs[k].ni;
            nack_n   = vecs[k].nn;
            hang_idx = vecs[k].hi;
            hang_n   = vecs[k].hn;
            do_reset();
            push_run(vecs[k].ni, vecs[k].nn, vecs[k].hi, vecs[k].hn);
            s0   = start_cnt;
            rstn = 1'b1;
            wait_first_start(n);
            check({vecs[k].name, "_pwrup_len"}, n, PWRUP_CYC + SETUP_CYC);
            wait_end();
            repeat (20) tick();
            check({vecs[k].name, "_done"}, 32'(cfg_done), vecs[k].done);
            check({vecs[k].name, "_err"}, 32'(cfg_err), vecs[k].err);
            check({vecs[k].name, "_idx"}, 32'(lut_index), vecs[k].idx);
            check({vecs[k].name, "_nack"}, 32'(nack_cnt), vecs[k].nacks);
            check({vecs[k].name, "_starts"}, start_cnt - s0, vecs[k].starts);
            check({vecs[k].name, "_start_low"}, 32'(start), 0);
            check({vecs[k].name, "_q_empty"}, exp_q.size(), 0);
            if (vecs[k].hn > 0) check({vecs[k].name, "_tmo_len"}, first_run, XFER_TMO + 1);
        end

        // Reset pulled mid-transfer of the last entry.
        nack_idx = -1; nack_n = 0; hang_idx = -1; hang_n = 0;
        do_reset();
        push_run(-1, 0, -1, 0);
        rstn = 1'b1;
        n = 0;
        while (!(start && lut_index == 8'd3) && n < 5000) begin
            tick();
            n++;
        end
        check("mid_reach_xfer3", 32'(start && lut_index == 8'd3), 1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_start", 32'(start), 0);
        check("mid_rst_idx", 32'(lut_index), 0);
        check("mid_rst_data", 32'(i2c_data), 0);
        repeat (3) tick();
        check("mid_q_empty", exp_q.size(), 0);
        push_run(-1, 0, -1, 0);
        s0   = start_cnt;
        rstn = 1'b1;
        wait_first_start(n);
        check("mid_pwrup_len", n, PWRUP_CYC + SETUP_CYC);
        wait_end();
        check("mid_done", 32'(cfg_done), 1);
        check("mid_nack", 32'(nack_cnt), 0);
        check("mid_starts", start_cnt - s0, 4);

        // cfg_go: ignored mid-transfer, restarts from DONE/ERR without clearing nack_cnt.
        nack_idx = 1; nack_n = 1;
        do_reset();
        push_run(1, 1, -1, 0);
        rstn = 1'b1;
        wait_end();
        check("go_first_nack", 32'(nack_cnt), 1);
        nack_idx = -1; nack_n = 0;
        push_run(-1, 0, -1, 0);
        s0     = start_cnt;
        cfg_go = 1'b1;
        tick();
        cfg_go = 1'b0;
        check("go_clr_done", 32'(cfg_done), 0);
        check("go_clr_err", 32'(cfg_err), 0);
        check("go_clr_idx", 32'(lut_index), 0);
        n = 1;
        while (!start && n < 50) begin
            tick();
            n++;
        end
        check("go_setup_len", n, SETUP_CYC + 1);
        cfg_go = 1'b1;
        tick();
        cfg_go = 1'b0;
        check("go_ign_start", 32'(start), 1);
        check("go_ign_idx", 32'(lut_index), 0);
        wait_end();
        check("go_run2_done", 32'(cfg_done), 1);
        check("go_run2_nack", 32'(nack_cnt), 1);
        check("go_run2_starts", start_cnt - s0, 4);
        push_run(-1, 0, -1, 0);
        s0     = start_cnt;
        cfg_go = 1'b1;
        tick();
        cfg_go = 1'b0;
        check("go_done_clr", 32'(cfg_done), 0);
        check("go_done_idx", 32'(lut_index), 0);
        wait_end();
        repeat (10) tick();
        check("go_run3_done", 32'(cfg_done), 1);
        check("go_run3_nack", 32'(nack_cnt), 1);
        check("go_run3_starts", start_cnt - s0, 4);
        check("go_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
